vga_timing_ctrl: RTL

Generates 640x480@60 Hz VGA raster timing and drives the pixel address bus consumed by the registered pixel-source block (`vmem`). It takes that block's `vga_data` back and emits it on the display pins as registered RGB, blanking and sync signals. Sync and blank are delayed to line up with the source's pipeline latency. The block sits between the pixel source and the VGA DAC/pins, on the 25 MHz pixel clock.

---
 rtl/vga_timing_ctrl_if.sv | 20 ++
 rtl/vga_timing_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl_if.sv
// Pixel-address bus between the VGA timing controller (master) and the
// registered pixel source (slave). The source returns vga_data a fixed
// number of cycles after it sees an address.
interface vga_timing_ctrl_if;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic [23:0] vga_data;

  modport master (
    output h_addr,
    output v_addr,
    input  vga_data
  );

  modport slave (
    input  h_addr,
    input  v_addr,
    output vga_data
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator. Stage 0 holds the h/v counters and drives the
// pixel address straight to the source. The active/sync/first-pixel flags
// travel through a DATA_LAT-deep delay line so that they meet the returned
// pixel data. An output register then captures the data and the flags on
// the same edge.
module vga_timing_ctrl #(
  parameter int H_DISP   = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_DISP   = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int DATA_LAT = 1,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  vga_timing_ctrl_if.master   pix,
  output logic                vga_hsync,
  output logic                vga_vsync,
  output logic                vga_blank_n,
  output logic [7:0]          vga_r,
  output logic [7:0]          vga_g,
  output logic [7:0]          vga_b,
  output logic                frame_start
);

  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_DISP);
  localparam logic [9:0] V_ACT_END  = 10'(V_DISP);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_DISP + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_DISP + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_DISP + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_DISP + V_FP + V_SYNC);

  // Flags that describe one raster position; all-zero means blanking, no sync.
  typedef struct packed {
    logic first;
    logic vs;
    logic hs;
    logic act;
  } flags_t;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  flags_t     flags_p0;
  flags_t     dly_p1_q [DATA_LAT];
  flags_t     dly_p1_d [DATA_LAT];
  flags_t     flags_p1;

  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       blank_n_q, blank_n_d;
  logic [7:0] r_q, r_d;
  logic [7:0] g_q, g_d;
  logic [7:0] b_q, b_d;
  logic       frame_start_q, frame_start_d;

  // ---- stage 0: raster counters and position flags ----

  // Next counter values; the vertical counter steps only at end of line.
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
  end

  // Raster counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Decode the current raster position into active/sync/first-pixel flags.
  always_comb begin
    flags_p0.act   = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    flags_p0.hs    = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
    flags_p0.vs    = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);
    flags_p0.first = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // Addresses come straight from the counters and read as 0 in blanking.
  assign pix.h_addr = flags_p0.act ? h_cnt_q : '0;
  assign pix.v_addr = flags_p0.act ? v_cnt_q : '0;

  // ---- stage 1: flag delay line matching the source latency ----

  // Shift the stage-0 flags one slot per cycle.
  always_comb begin
    dly_p1_d[0] = flags_p0;
    for (int i = 1; i < DATA_LAT; i++) begin
      dly_p1_d[i] = dly_p1_q[i-1];
    end
  end

  // Delay-line registers; reset flushes them so no stale pixels leak out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DATA_LAT; i++) begin
        dly_p1_q[i] <= '0;
      end
    end else begin
      dly_p1_q <= dly_p1_d;
    end
  end

  assign flags_p1 = dly_p1_q[DATA_LAT-1];

  // ---- stage 2: output register, data and flags captured together ----

  // Blank the colour outside the active area and apply sync polarity.
  always_comb begin
    blank_n_d     = flags_p1.act;
    r_d           = flags_p1.act ? pix.vga_data[23:16] : 8'h00;
    g_d           = flags_p1.act ? pix.vga_data[15:8]  : 8'h00;
    b_d           = flags_p1.act ? pix.vga_data[7:0]   : 8'h00;
    hsync_d       = flags_p1.hs ~^ SYNC_POL;
    vsync_d       = flags_p1.vs ~^ SYNC_POL;
    frame_start_d = flags_p1.first;
  end

  // Output registers; reset drives syncs to their inactive level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blank_n_q     <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      blank_n_q     <= blank_n_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_blank_n = blank_n_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign frame_start = frame_start_q;

endmodule
